text_console_buf: RTL and testbench

- Character-cell text buffer feeding the VGA text-mode display stage.
- Accepts an ASCII byte stream from the CPU/keyboard side with a valid/ready handshake and manages a cursor, line wrap, newline, backspace, form-feed clear and hardware scrolling.
- Exposes a logical read port that the display stage drives with its block address (row*COLS+col) and receives the ASCII code back.
- Scrolling uses a circular top-row pointer, so no bulk copy is needed.

---
 rtl/text_console_buf.sv | 215 +++++++++++++++++++++
 tb/tb_text_console_buf.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_buf.sv
// -----------------------------------------------------------------------------
// text_console_buf
//   Character-cell text buffer for the VGA text-mode display stage. Accepts an
//   ASCII stream over a valid/ready handshake and maintains a cursor with line
//   wrap, LF, CR, backspace, form-feed clear and hardware scrolling. Scrolling
//   moves a circular top-row pointer instead of copying the screen.
//
// Ports
//   clk          system clock (display pixel clock domain)
//   reset        asynchronous active-low reset
//   wr_valid     producer has a character
//   wr_char      ASCII code, sampled only on an accepted transfer
//   wr_ready     block can accept (transfer on wr_valid && wr_ready at posedge)
//   rd_addr      logical cell address row*COLS+col from the display stage
//   rd_data      registered ASCII at rd_addr (0x20 when out of range)
//   cursor_addr  logical cursor position cur_row*COLS+cur_col
//   busy         ~wr_ready
// -----------------------------------------------------------------------------
module text_console_buf #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [7:0]    wr_char,
    output logic          wr_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] cursor_addr,
    output logic          busy
);

    localparam int             NCELL       = COLS * ROWS;
    localparam logic [AW-1:0]  L_COLS      = AW'(COLS);
    localparam logic [AW-1:0]  L_LAST_COL  = AW'(COLS - 1);
    localparam logic [AW-1:0]  L_LAST_ROW  = AW'(ROWS - 1);
    localparam logic [AW-1:0]  L_NCELL     = AW'(NCELL);
    localparam logic [AW-1:0]  L_LAST_CELL = AW'(NCELL - 1);
    localparam logic [AW-1:0]  L_TOP_MAX   = AW'((ROWS - 1) * COLS);
    localparam logic [7:0]     SPACE       = 8'h20;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCROLL_CLR
    } state_t;

    // Fold a sum in [0, 2*NCELL) back into the physical cell range.
    function automatic logic [AW-1:0] fold(input logic [AW:0] v);
        logic [AW:0] d;
        d = v - {1'b0, L_NCELL};
        return (v >= {1'b0, L_NCELL}) ? d[AW-1:0] : v[AW-1:0];
    endfunction

    state_t         r_state, w_next_state;
    logic [AW-1:0]  r_clr_ptr;      // physical address being blanked
    logic [AW-1:0]  r_clr_cnt;      // cells blanked so far during a scroll
    logic [AW-1:0]  r_top_base;     // physical address of logical row 0
    logic [AW-1:0]  r_cur_row, r_cur_col, r_cur_phys, r_cursor_addr;
    logic [7:0]     r_rd_data;
    logic [7:0]     r_mem [NCELL];

    logic           w_ready, w_accept, w_we;
    logic [AW-1:0]  w_waddr;
    logic [7:0]     w_wdata;
    logic           w_is_print, w_is_lf, w_is_cr, w_is_bs, w_is_ff;
    logic           w_at_home, w_row_adv, w_scroll, w_rd_oob;
    logic [AW-1:0]  w_phys_dec, w_phys_nl, w_top_next, w_rd_phys;

    assign wr_ready    = w_ready;
    assign busy        = ~w_ready;
    assign rd_data     = r_rd_data;
    assign cursor_addr = r_cursor_addr;

    assign w_accept   = wr_valid & w_ready;
    assign w_is_print = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
    assign w_is_lf    = (wr_char == 8'h0A);
    assign w_is_cr    = (wr_char == 8'h0D);
    assign w_is_bs    = (wr_char == 8'h08);
    assign w_is_ff    = (wr_char == 8'h0C);
    assign w_at_home  = (r_cur_row == '0) && (r_cur_col == '0);
    assign w_row_adv  = w_accept && ((w_is_print && r_cur_col == L_LAST_COL) || w_is_lf);
    assign w_scroll   = w_row_adv && (r_cur_row == L_LAST_ROW);

    // Previous cell in the circular store; from column 0 this is the last
    // column of the row above.
    assign w_phys_dec = (r_cur_phys == '0) ? L_LAST_CELL : r_cur_phys - 1'b1;
    // Column 0 of the next physical row. On the bottom row this lands on the
    // old top row, which is exactly where the cursor sits after a scroll.
    assign w_phys_nl  = fold({1'b0, r_cur_phys} - {1'b0, r_cur_col} + {1'b0, L_COLS});
    assign w_top_next = (r_top_base == L_TOP_MAX) ? '0 : r_top_base + L_COLS;

    assign w_rd_oob   = (rd_addr >= L_NCELL);
    assign w_rd_phys  = w_rd_oob ? '0 : fold({1'b0, rd_addr} + {1'b0, r_top_base});

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_CLEAR;
        else        r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CLEAR:      if (r_clr_ptr == L_LAST_CELL) w_next_state = ST_IDLE;
            ST_IDLE: begin
                if (w_accept && w_is_ff) w_next_state = ST_CLEAR;
                else if (w_scroll)       w_next_state = ST_SCROLL_CLR;
            end
            ST_SCROLL_CLR: if (r_clr_cnt == L_LAST_COL) w_next_state = ST_IDLE;
            default:       w_next_state = ST_CLEAR;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_waddr = r_clr_ptr;
        w_wdata = SPACE;
        case (r_state)
            ST_CLEAR, ST_SCROLL_CLR: w_we = 1'b1;
            ST_IDLE: begin
                w_ready = 1'b1;
                w_waddr = r_cur_phys;
                if (wr_valid && w_is_print) begin
                    w_we    = 1'b1;
                    w_wdata = wr_char;
                end else if (wr_valid && w_is_bs && !w_at_home) begin
                    w_we    = 1'b1;
                    w_waddr = w_phys_dec;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_ptr     <= '0;
            r_clr_cnt     <= '0;
            r_top_base    <= '0;
            r_cur_row     <= '0;
            r_cur_col     <= '0;
            r_cur_phys    <= '0;
            r_cursor_addr <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: r_clr_ptr <= (r_clr_ptr == L_LAST_CELL) ? '0 : r_clr_ptr + 1'b1;
                ST_SCROLL_CLR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
                ST_IDLE: if (w_accept) begin
                    if (w_is_ff) begin
                        r_top_base    <= '0;
                        r_cur_row     <= '0;
                        r_cur_col     <= '0;
                        r_cur_phys    <= '0;
                        r_cursor_addr <= '0;
                        r_clr_ptr     <= '0;
                    end else if (w_row_adv) begin
                        r_cur_col  <= '0;
                        r_cur_phys <= w_phys_nl;
                        if (w_scroll) begin
                            // The old top row becomes the new bottom row.
                            r_top_base    <= w_top_next;
                            r_cursor_addr <= r_cursor_addr - r_cur_col;
                            r_clr_ptr     <= r_top_base;
                            r_clr_cnt     <= '0;
                        end else begin
                            r_cur_row     <= r_cur_row + 1'b1;
                            r_cursor_addr <= r_cursor_addr + L_COLS - r_cur_col;
                        end
                    end else if (w_is_print) begin
                        r_cur_col     <= r_cur_col + 1'b1;
                        r_cur_phys    <= r_cur_phys + 1'b1;
                        r_cursor_addr <= r_cursor_addr + 1'b1;
                    end else if (w_is_cr) begin
                        r_cur_col     <= '0;
                        r_cur_phys    <= r_cur_phys - r_cur_col;
                        r_cursor_addr <= r_cursor_addr - r_cur_col;
                    end else if (w_is_bs && !w_at_home) begin
                        r_cur_phys    <= w_phys_dec;
                        r_cursor_addr <= r_cursor_addr - 1'b1;
                        if (r_cur_col == '0) begin
                            r_cur_row <= r_cur_row - 1'b1;
                            r_cur_col <= L_LAST_COL;
                        end else begin
                            r_cur_col <= r_cur_col - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the character store has no reset; the CLEAR sweep initialises it,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // Same-cycle write to the read cell returns the old byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rd_data <= SPACE;
        else        r_rd_data <= w_rd_oob ? SPACE : r_mem[w_rd_phys];
    end

endmodule

// File: tb/tb_text_console_buf.sv
// -----------------------------------------------------------------------------
// tb_text_console_buf
//   Self-checking bench. A logical screen model (2-D array, scroll by row
//   shift, stall counter) predicts wr_ready, busy, cursor_addr and rd_data; a
//   compare process checks them on every falling edge. Directed sequences add
//   hand-computed literal expectations, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_text_console_buf;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int NCELL = COLS * ROWS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_char = 8'h00;
    logic [AW-1:0] rd_addr = '0;
    logic          wr_ready, busy;
    logic [7:0]    rd_data;
    logic [AW-1:0] cursor_addr;

    always #5 clk = ~clk;

    text_console_buf #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_char     (wr_char),
        .wr_ready    (wr_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cursor_addr (cursor_addr),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (logical screen) ----------------
    logic [7:0] scr [ROWS][COLS];
    int         m_row, m_col, m_stall;
    logic [7:0] m_exp_rd;
    bit         m_rd_valid;

    function automatic void m_blank();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
    endfunction

    function automatic void m_newline();
        m_col = 0;
        if (m_row == ROWS - 1) begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
            m_stall = COLS;
        end else begin
            m_row++;
        end
    endfunction

    function automatic void m_apply(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[m_row][m_col] = ch;
            m_col++;
            if (m_col == COLS) m_newline();
        end else begin
            case (ch)
                8'h0A: m_newline();
                8'h0D: m_col = 0;
                8'h08: begin
                    if (m_col > 0) begin
                        m_col--;
                        scr[m_row][m_col] = 8'h20;
                    end else if (m_row > 0) begin
                        m_row--;
                        m_col = COLS - 1;
                        scr[m_row][m_col] = 8'h20;
                    end
                end
                8'h0C: begin
                    m_blank();
                    m_row   = 0;
                    m_col   = 0;
                    m_stall = NCELL;
                end
                default: ;
            endcase
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_blank();
            m_row      = 0;
            m_col      = 0;
            m_stall    = NCELL;
            m_exp_rd   = 8'h20;
            m_rd_valid = 1'b1;
        end else begin
            // The read sees the screen as it was before this edge's update.
            if (int'(rd_addr) >= NCELL) begin
                m_exp_rd   = 8'h20;
                m_rd_valid = 1'b1;
            end else if (m_stall == 0) begin
                m_exp_rd   = scr[int'(rd_addr) / COLS][int'(rd_addr) % COLS];
                m_rd_valid = 1'b1;
            end else begin
                m_rd_valid = 1'b0;
            end
            if (m_stall > 0) m_stall--;
            else if (wr_valid) m_apply(wr_char);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("wr_ready", 32'(wr_ready), 32'(reset && m_stall == 0));
        check("busy", 32'(busy), 32'(!(reset && m_stall == 0)));
        check("cursor_addr", 32'(cursor_addr), 32'(m_row * COLS + m_col));
        if (m_rd_valid) check("rd_data", 32'(rd_data), 32'(m_exp_rd));
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!wr_ready && cycles < 5000) begin
            @(negedge clk);
            cycles++;
        end
        if (!wr_ready) check("ready_timeout", 32'(wr_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] ch);
        int budget;
        budget   = 0;
        wr_valid = 1'b1;
        wr_char  = ch;
        while (!wr_ready && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (!wr_ready) check("send_timeout", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic read_cell(input int addr, input logic [7:0] exp, input string name);
        rd_addr = AW'(addr);
        @(negedge clk);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic sweep_blank(input string name);
        for (int a = 0; a < NCELL; a++) begin
            rd_addr = AW'(a);
            @(negedge clk);
            check(name, 32'(rd_data), 32'h20);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, acc, r;
        logic [7:0] ch;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(wr_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_cursor", 32'(cursor_addr), 32'd0);
        check("reset_rd", 32'(rd_data), 32'h20);
        reset = 1'b1;
        wait_ready(cnt);
        check("clear_cycles", 32'(cnt), 32'd2100);
        read_cell(0, 8'h20, "rd_0");
        read_cell(1069, 8'h20, "rd_1069");
        read_cell(2099, 8'h20, "rd_2099");
        read_cell(2100, 8'h20, "rd_oob");

        // Two printable characters
        send(8'h41);
        send(8'h42);
        read_cell(0, 8'h41, "rd_A");
        read_cell(1, 8'h42, "rd_B");
        check("cursor_AB", 32'(cursor_addr), 32'd2);

        // Form feed after text
        send(8'h0C);
        check("ff_busy", 32'(wr_ready), 32'd0);
        wait_ready(cnt);
        check("ff_cycles", 32'(cnt), 32'd2100);
        check("ff_cursor", 32'(cursor_addr), 32'd0);
        sweep_blank("ff_sweep");

        // Line wrap and backspace
        repeat (70) send(8'h78);
        check("wrap_cursor", 32'(cursor_addr), 32'd70);
        send(8'h08);
        check("bs_wrap_cursor", 32'(cursor_addr), 32'd69);
        read_cell(69, 8'h20, "bs_cell69");
        read_cell(68, 8'h78, "cell68_x");
        send(8'h0D);
        check("cr_cursor", 32'(cursor_addr), 32'd0);
        send(8'h08);
        check("bs_home_cursor", 32'(cursor_addr), 32'd0);

        // Scroll
        send(8'h51);
        repeat (29) send(8'h0A);
        check("lf29_cursor", 32'(cursor_addr), 32'd2030);
        send(8'h5A);
        send(8'h0A);
        wait_ready(cnt);
        check("scroll_cycles", 32'(cnt), 32'd70);
        read_cell(1960, 8'h5A, "scroll_Z");
        read_cell(0, 8'h20, "scroll_Q_gone");
        for (int c = 0; c < COLS; c++) read_cell(2030 + c, 8'h20, "scroll_bottom");
        check("scroll_cursor", 32'(cursor_addr), 32'd2030);

        // Continuous valid through a scroll stall
        acc      = 0;
        wr_valid = 1'b1;
        wr_char  = 8'h4B;
        for (int i = 0; i < 200; i++) begin
            if (wr_ready) acc++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("hold_accepts", 32'(acc), 32'd130);
        check("hold_cursor", 32'(cursor_addr), 32'd2090);
        read_cell(1960, 8'h4B, "hold_r28c0");
        read_cell(2029, 8'h4B, "hold_r28c69");
        read_cell(2089, 8'h4B, "hold_r29c59");
        read_cell(2090, 8'h20, "hold_r29c60");

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 700)      ch = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 790) ch = 8'h0A;
            else if (r < 830) ch = 8'h0D;
            else if (r < 920) ch = 8'h08;
            else if (r < 922) ch = 8'h0C;
            else              ch = 8'($urandom_range(0, 255));
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_char  = ch;
            if ($urandom_range(0, 9) == 0) rd_addr = AW'($urandom_range(0, 4095));
            else                           rd_addr = AW'($urandom_range(0, NCELL - 1));
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wait_ready(cnt);

        // Reset in the middle of a scroll
        repeat (30) send(8'h0A);
        send(8'h0A);
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midreset_ready", 32'(wr_ready), 32'd0);
        check("midreset_cursor", 32'(cursor_addr), 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        wait_ready(cnt);
        check("midreset_clear_cycles", 32'(cnt), 32'd2100);
        sweep_blank("midreset_sweep");
        send(8'h4D);
        read_cell(0, 8'h4D, "midreset_phys0");
        check("midreset_cursor_after", 32'(cursor_addr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
